// File: rtl/tt_uart_pkg.sv
// Shared types and constants for the single-pin UART demo transmitter.
package tt_uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   localparam logic [7:0] CHAR_FIRST = 8'h41;
   localparam logic [7:0] CHAR_LAST  = 8'h5A;
   localparam int         DATA_BITS  = 8;

   // Alphabet stepping: 'Z' rolls back over to 'A'.
   function automatic logic [7:0] next_char(input logic [7:0] c);
      return (c == CHAR_LAST) ? CHAR_FIRST : c + 8'd1;
   endfunction

endpackage

// File: rtl/uart_tx_frame.sv
// 8N1 frame engine: baud counter, bit index, shift register and the TX line flop.
module uart_tx_frame
   import tt_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 87
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] data_in,
   output logic       busy,
   output logic       done,
   output logic       out
);

   localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);
   localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

   state_t      state;
   logic [15:0] baud_cnt;
   logic [2:0]  bit_idx;
   logic [7:0]  shift;

   wire bit_end = (baud_cnt == LAST_CNT);

   assign busy = (state != IDLE);
   // High on the edge that returns the engine to IDLE, so the caller can advance in step.
   assign done = (state == STOP) && bit_end;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         out      <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               out      <= 1'b1;
               baud_cnt <= '0;
               bit_idx  <= '0;
               if (start) begin
                  shift <= data_in;
                  state <= START;
                  out   <= 1'b0;
               end
            end
            START: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  state    <= DATA;
                  out      <= shift[0];
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (bit_idx == LAST_BIT) begin
                     bit_idx <= '0;
                     state   <= STOP;
                     out     <= 1'b1;
                  end else begin
                     // Present the next bit straight from the pre-shift value.
                     bit_idx <= bit_idx + 3'd1;
                     shift   <= {1'b0, shift[7:1]};
                     out     <= shift[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            STOP: begin
               out <= 1'b1;
               if (bit_end) begin
                  baud_cnt <= '0;
                  state    <= IDLE;
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            default: begin
               state <= IDLE;
               out   <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/tt_um_example_uart.sv
// Top: synchronises the trigger pin, detects its rising edge and sends 'A'..'Z' frames.
module tt_um_example_uart
   import tt_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 87
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in,
   output logic out
);

   logic       s1;
   logic       s2;
   logic       s3;
   logic [7:0] char_reg;
   logic       trig;
   logic       busy;
   logic       done;

   // Despite its name, rst_n is an active-high asynchronous reset.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign trig = s2 & ~s3;

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         char_reg <= CHAR_FIRST;
      end else if (done) begin
         char_reg <= next_char(char_reg);
      end
   end

   // Triggers seen while busy are simply not accepted by the frame engine.
   uart_tx_frame #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_frame (
      .clk    (clk),
      .rst    (rst_n),
      .start  (trig),
      .data_in(char_reg),
      .busy   (busy),
      .done   (done),
      .out    (out)
   );

endmodule

// File: tb/tb_tt_um_example_uart.sv
// Randomised bench: a frame-level model predicts every line bit and decoded byte.
module tb_tt_um_example_uart;

   localparam int CPB   = 4;
   localparam int FRAME = 10 * CPB;
   localparam int LAT   = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in = 1'b0;
   logic out;

   tt_um_example_uart #(.CLKS_PER_BIT(CPB)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .in   (in),
      .out  (out)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference model: accepted frames with their launch cycle and byte.
   typedef struct {
      int unsigned l;
      logic [7:0]  b;
   } frame_t;

   frame_t      q[$];
   logic [7:0]  m_char = 8'h41;
   bit          have_last = 1'b0;
   int unsigned last_l = 0;
   bit          chk_en = 1'b0;
   logic [7:0]  dec;
   logic [7:0]  dec_log[$];

   task automatic model_reset();
      q.delete();
      m_char    = 8'h41;
      have_last = 1'b0;
   endtask

   // A rising edge launches at cycle l only if the previous frame fully ended before l.
   task automatic trigger_at(input int unsigned l);
      frame_t f;
      if (!have_last || l >= last_l + FRAME + 1) begin
         f.l = l;
         f.b = m_char;
         q.push_back(f);
         last_l    = l;
         have_last = 1'b1;
         m_char    = (m_char == 8'h5A) ? 8'h41 : m_char + 8'd1;
      end
   endtask

   task automatic pulse(input int hi, input int lo);
      in = 1'b1;
      trigger_at(cyc + LAT);
      repeat (hi) @(negedge clk);
      in = 1'b0;
      repeat (lo) @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b1;
      in    = 1'b0;
      model_reset();
      repeat (3) begin
         @(negedge clk);
         #1 check("rst_out", {31'd0, out}, 32'd1);
      end
      rst_n = 1'b0;
   endtask

   // Line checker: expected level every cycle, plus a decoded byte per frame.
   initial begin
      int unsigned n;
      int unsigned off;
      int          bi;
      logic        exp;
      forever begin
         @(negedge clk);
         #1;
         if (chk_en) begin
            n = cyc;
            while (q.size() > 0 && n >= q[0].l + FRAME) void'(q.pop_front());
            exp = 1'b1;
            if (q.size() > 0 && n >= q[0].l) begin
               off = n - q[0].l;
               bi  = int'(off / CPB);
               if (bi == 0) exp = 1'b0;
               else if (bi == 9) exp = 1'b1;
               else exp = q[0].b[bi-1];
               if ((off % CPB) == 2 && bi >= 1 && bi <= 8) dec[bi-1] = out;
               if (off == FRAME - 1) begin
                  check("byte", {24'd0, dec}, {24'd0, q[0].b});
                  dec_log.push_back(dec);
                  $display("frame launched at cycle %0d: byte 0x%02h (expected 0x%02h)", q[0].l, dec, q[0].b);
               end
            end
            check("line", {31'd0, out}, {31'd0, exp});
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned l0;
      int          base;
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk_en = 1'b1;
      do_reset();
      repeat (20) @(negedge clk);

      // Single pulse, then four spaced pulses.
      pulse(10, 50);
      base = dec_log.size();
      repeat (4) pulse(8, 52);
      check("four_n", 32'(dec_log.size() - base), 32'd4);
      if (dec_log.size() - base == 4) begin
         check("four_0", {24'd0, dec_log[base]},   32'h42);
         check("four_3", {24'd0, dec_log[base+3]}, 32'h45);
      end

      // Second edge while busy is lost, even though in stays high.
      do_reset();
      repeat (3) @(negedge clk);
      base = dec_log.size();
      in = 1'b1;
      l0 = cyc + LAT;
      trigger_at(l0);
      repeat (5) @(negedge clk);
      in = 1'b0;
      while (cyc < l0 + 12) @(negedge clk);
      in = 1'b1;
      trigger_at(cyc + LAT);
      repeat (60) @(negedge clk);
      in = 1'b0;
      repeat (5) @(negedge clk);
      pulse(5, 50);
      check("busy_n", 32'(dec_log.size() - base), 32'd2);
      if (dec_log.size() - base == 2) begin
         check("busy_0", {24'd0, dec_log[base]},   32'h41);
         check("busy_1", {24'd0, dec_log[base+1]}, 32'h42);
      end

      // Alphabet wrap.
      do_reset();
      repeat (3) @(negedge clk);
      base = dec_log.size();
      repeat (27) pulse(4, 46);
      check("wrap_n", 32'(dec_log.size() - base), 32'd27);
      if (dec_log.size() - base == 27) begin
         check("wrap_26", {24'd0, dec_log[base+25]}, 32'h5A);
         check("wrap_27", {24'd0, dec_log[base+26]}, 32'h41);
      end

      // Asynchronous abort mid-DATA while the line is low.
      do_reset();
      repeat (3) @(negedge clk);
      in = 1'b1;
      l0 = cyc + LAT;
      trigger_at(l0);
      repeat (5) @(negedge clk);
      in = 1'b0;
      while (cyc < l0 + 9) @(negedge clk);
      #2 check("pre_abort", {31'd0, out}, 32'd0);
      rst_n = 1'b1;
      model_reset();
      #1 check("async_rst", {31'd0, out}, 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      base = dec_log.size();
      pulse(10, 50);
      check("abort_n", 32'(dec_log.size() - base), 32'd1);
      if (dec_log.size() - base == 1)
         check("abort_chr", {24'd0, dec_log[base]}, 32'h41);

      // Random pulse train: widths and gaps span both accepted and discarded edges.
      repeat (40) pulse(int'($urandom_range(1, 15)), int'($urandom_range(1, 60)));
      repeat (FRAME + 10) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
